// File: rtl/fc_layer_engine_if.sv
// fc_layer_engine_if: control, RAM read, input-vector and result signals of the FC layer engine
interface fc_layer_engine_if;
    logic        load;
    logic        start;
    logic [15:0] layer_base;
    logic [15:0] ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_rdata;
    logic [15:0] in_addr;
    logic [15:0] in_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic [15:0] out_index;
    logic        busy;
    logic        done;

    modport master (
        output load, start, layer_base, ram_rdata, in_data,
        input  ram_addr, ram_rd, in_addr, out_valid, out_data, out_index, busy, done
    );

    modport slave (
        input  load, start, layer_base, ram_rdata, in_data,
        output ram_addr, ram_rd, in_addr, out_valid, out_data, out_index, busy, done
    );
endinterface

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: fetches bias/weight bytes from RAM and MACs one dense Q8.8 layer, one neuron at a time
module fc_layer_engine #(
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    parameter int ACC_W   = 40,
    parameter int RELU    = 1
) (
    input logic              clk,
    input logic              RST,
    fc_layer_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, B0, B1, W0, W1, FLUSH, EMIT, DONE} state_t;

    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-32768);

    state_t                  state, state_n;
    logic [15:0]             bptr, wptr, k, n, od, oi;
    logic [7:0]              lo;
    logic signed [15:0]      x, word, res_s, res;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] acc, acc_n, shr, bias_ext, prod_ext;
    logic                    run, take, last_k, last_n;

    assign run      = state inside {B0, B1, W0, W1, FLUSH, EMIT};
    assign take     = state == IDLE && bus.start && !bus.load;
    assign last_k   = k == 16'(NUM_IN - 1);
    assign last_n   = n == 16'(NUM_OUT - 1);
    assign word     = {bus.ram_rdata, lo};
    assign prod     = 32'(word) * 32'(x);
    assign bias_ext = {{(ACC_W-24){word[15]}}, word, 8'h00};
    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
    assign bus.out_data  = od;
    assign bus.out_index = oi;

    // accumulator update: bias load on the first W0, MAC of the previous weight on later W0s and FLUSH
    always_comb begin
        acc_n = (state == W0 && k == '0) ? bias_ext :
                (state == W0 || state == FLUSH) ? acc + prod_ext : acc;
        shr   = acc_n >>> 8;
        res_s = shr > MAXV ? 16'sh7fff : shr < MINV ? 16'sh8000 : shr[15:0];
        res   = (RELU != 0 && res_s[15]) ? 16'sh0000 : res_s;
    end

    // state register
    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    // next-state and bus outputs; load during a pass aborts straight to IDLE
    always_comb begin
        state_n = state;
        if (run && bus.load) state_n = IDLE;
        else begin
            unique case (state)
                IDLE:  state_n = take ? B0 : IDLE;
                B0:    state_n = B1;
                B1:    state_n = W0;
                W0:    state_n = W1;
                W1:    state_n = last_k ? FLUSH : W0;
                FLUSH: state_n = EMIT;
                EMIT:  state_n = last_n ? DONE : B0;
                DONE:  state_n = IDLE;
            endcase
        end
        bus.ram_rd    = state inside {B0, B1, W0, W1};
        bus.ram_addr  = state == B0 ? bptr :
                        state == B1 ? bptr + 16'd1 :
                        state == W0 ? wptr :
                        state == W1 ? wptr + 16'd1 : 16'd0;
        bus.in_addr   = state == W0 ? k : 16'd0;
        bus.out_valid = state == EMIT;
        bus.done      = state == DONE;
        bus.busy      = run;
    end

    // datapath: address pointers, byte/input capture, counters, accumulator and result registers
    always_ff @(posedge clk) begin
        if (RST) begin
            bptr <= '0;
            wptr <= '0;
            k    <= '0;
            n    <= '0;
            lo   <= '0;
            x    <= '0;
            acc  <= '0;
            od   <= '0;
            oi   <= '0;
        end else begin
            if (take) begin
                bptr <= bus.layer_base;
                wptr <= bus.layer_base + 16'(2 * NUM_OUT);
                k    <= '0;
                n    <= '0;
            end
            if (state == B1 || state == W1) lo <= bus.ram_rdata;
            if (state == B1) bptr <= bptr + 16'd2;
            if (state == W1) begin
                x    <= bus.in_data;
                wptr <= wptr + 16'd2;
                k    <= last_k ? 16'd0 : k + 16'd1;
            end
            if (state == EMIT) n <= n + 16'd1;
            if (state == FLUSH && !bus.load) begin
                od <= res;
                oi <= n;
            end
            acc <= acc_n;
        end
    end
endmodule
